pps_decode: RTL and testbench

//  Streaming inverse of the parallel prefix-sum unit. It accepts vectors of N cumulative sums and

---
 rtl/eau_pkg.sv | 19 +
 rtl/pps_decode_lane.sv | 26 ++
 rtl/pps_decode.sv | 121 ++++++++++++
 tb/tb_pps_decode.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eau_pkg.sv
// Shared EAU definitions: default lane geometry and lane-slice helpers
// used by the prefix-sum encoder/decoder pair.
package eau_pkg;

    localparam int DEF_NW = 5;
    localparam int DEF_IW = 4;
    localparam int DEF_OW = 6;
    localparam int DEF_CW = 16;
    localparam int DEF_N  = 1 << DEF_NW;

    function automatic int lane_lo(input int k, input int w);
        return k * w;
    endfunction

    function automatic int lane_hi(input int k, input int w);
        return (k * w) + w - 1;
    endfunction

endpackage

// File: rtl/pps_decode_lane.sv
// One lane of the prefix-sum decoder: modular difference of two adjacent
// cumulative sums, truncated to the element width with an overflow flag.
module pps_decode_lane #(
    parameter int IW = 4,
    parameter int OW = 6
) (
    input  logic [OW-1:0] prev,
    input  logic [OW-1:0] cur,
    output logic [IW-1:0] val,
    output logic          ovf
);

    logic [OW-1:0] diff;

    assign diff = cur - prev;
    assign val  = diff[IW-1:0];

    generate
        if (OW > IW) begin : g_ovf
            assign ovf = |diff[OW-1:IW];
        end else begin : g_no_ovf
            assign ovf = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/pps_decode.sv
// Streaming prefix-sum decoder: recovers per-element values from cumulative
// sums, carrying the last lane across beats of a stream, with one output stage.
module pps_decode
    import eau_pkg::*;
#(
    parameter int NW = DEF_NW,
    parameter int IW = DEF_IW,
    parameter int OW = DEF_OW,
    parameter int CW = DEF_CW
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_first,
    input  logic                    in_last,
    input  logic [OW*(1<<NW)-1:0]   in_psum,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic [IW*(1<<NW)-1:0]   out_data,
    output logic [(1<<NW)-1:0]      out_ovf,
    output logic                    err,
    output logic [CW-1:0]           beats
);

    localparam int N = 1 << NW;

    logic            out_valid_q, out_valid_d;
    logic            out_last_q,  out_last_d;
    logic [IW*N-1:0] out_data_q,  out_data_d;
    logic [N-1:0]    out_ovf_q,   out_ovf_d;
    logic            err_q,       err_d;
    logic [CW-1:0]   beats_q,     beats_d;
    logic [OW-1:0]   carry_q,     carry_d;

    logic            accept;
    logic [OW-1:0]   prev0;
    logic [IW*N-1:0] lane_val;
    logic [N-1:0]    lane_ovf;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign prev0    = in_first ? '0 : carry_q;

    // Lane 0 differences against the stream carry, every other lane against its neighbour.
    generate
        for (genvar k = 0; k < N; k++) begin : g_lane
            if (k == 0) begin : g_first
                pps_decode_lane #(.IW(IW), .OW(OW)) u_lane (
                    .prev (prev0),
                    .cur  (in_psum[lane_lo(0, OW) +: OW]),
                    .val  (lane_val[lane_lo(0, IW) +: IW]),
                    .ovf  (lane_ovf[0])
                );
            end else begin : g_rest
                pps_decode_lane #(.IW(IW), .OW(OW)) u_lane (
                    .prev (in_psum[lane_lo(k-1, OW) +: OW]),
                    .cur  (in_psum[lane_lo(k, OW) +: OW]),
                    .val  (lane_val[lane_lo(k, IW) +: IW]),
                    .ovf  (lane_ovf[k])
                );
            end
        end
    endgenerate

    always_comb begin
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        err_d       = err_q;
        beats_d     = beats_q;
        carry_d     = carry_q;

        if (accept) begin
            out_valid_d = 1'b1;
            out_last_d  = in_last;
            out_data_d  = lane_val;
            out_ovf_d   = lane_ovf;
            // A closed stream leaves carry at 0 so an unflagged next stream starts clean.
            carry_d     = in_last ? '0 : in_psum[OW*N-1 -: OW];
            err_d       = in_first ? (|lane_ovf) : (err_q || (|lane_ovf));
            if (in_first) begin
                beats_d = {{(CW-1){1'b0}}, 1'b1};
            end else if (beats_q != {CW{1'b1}}) begin
                beats_d = beats_q + {{(CW-1){1'b0}}, 1'b1};
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= '0;
            err_q       <= 1'b0;
            beats_q     <= '0;
            carry_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
            err_q       <= err_d;
            beats_q     <= beats_d;
            carry_q     <= carry_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;
    assign err       = err_q;
    assign beats     = beats_q;

endmodule

// File: tb/tb_pps_decode.sv
// Scoreboard bench for pps_decode (N=4, IW=4, OW=6): directed stream cases
// followed by randomized beats under random backpressure.
module tb_pps_decode;

    localparam int NW = 2;
    localparam int N  = 4;
    localparam int IW = 4;
    localparam int OW = 6;
    localparam int CW = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic              in_first;
    logic              in_last;
    logic [OW*N-1:0]   in_psum;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic [IW*N-1:0]   out_data;
    logic [N-1:0]      out_ovf;
    logic              err;
    logic [CW-1:0]     beats;

    typedef struct {
        logic [IW*N-1:0] data;
        logic [N-1:0]    ovf;
        logic            last;
        logic            err;
        logic [CW-1:0]   beats;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int passed = 0;
    int ready_mode = 0;

    int m_carry = 0;
    bit m_err   = 1'b0;
    int m_beats = 0;

    pps_decode #(.NW(NW), .IW(IW), .OW(OW), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_first  (in_first),
        .in_last   (in_last),
        .in_psum   (in_psum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .err       (err),
        .beats     (beats)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [OW*N-1:0] mk(input int a, input int b, input int c, input int d);
        logic [OW*N-1:0] r;
        r[0*OW +: OW] = a[OW-1:0];
        r[1*OW +: OW] = b[OW-1:0];
        r[2*OW +: OW] = c[OW-1:0];
        r[3*OW +: OW] = d[OW-1:0];
        return r;
    endfunction

    // Reference: element k is psum[k] minus its predecessor, modulo 64; anything above 15 overflows.
    task automatic modelPush(input logic [OW*N-1:0] p, input bit first, input bit last);
        exp_t e;
        int   prev;
        int   cur;
        int   d;
        bit   any;
        prev = first ? 0 : m_carry;
        any  = 1'b0;
        for (int k = 0; k < N; k++) begin
            cur = int'(p[k*OW +: OW]);
            d   = (cur - prev + 64) % 64;
            e.data[k*IW +: IW] = 4'(d % 16);
            e.ovf[k] = (d > 15);
            any = any | (d > 15);
            prev = cur;
        end
        m_err   = first ? any : (m_err | any);
        m_beats = first ? 1 : ((m_beats == 65535) ? 65535 : m_beats + 1);
        m_carry = last ? 0 : int'(p[(N-1)*OW +: OW]);
        e.last  = last;
        e.err   = m_err;
        e.beats = 16'(m_beats);
        sb.push_back(e);
    endtask

    task automatic applyStimulus(input logic [OW*N-1:0] p, input bit first, input bit last);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        in_valid = 1'b1;
        in_first = first;
        in_last  = last;
        in_psum  = p;
        while (!done && n < 200) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            @(posedge clk);
            n++;
        end
        if (done) begin
            modelPush(p, first, last);
        end else begin
            checkOutput("accept_timeout", 32'(done), 32'd1);
        end
        #1;
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
        in_psum  = 'x;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: compare each beat as it is consumed, and check stability while stalled.
    initial begin
        exp_t e;
        exp_t snap;
        logic snap_valid;
        bit   held;
        held = 1'b0;
        snap_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held = 1'b0;
                continue;
            end
            if (held) begin
                checkOutput("hold_valid", 32'(out_valid), 32'(snap_valid));
                checkOutput("hold_data",  32'(out_data),  32'(snap.data));
                checkOutput("hold_ovf",   32'(out_ovf),   32'(snap.ovf));
                checkOutput("hold_last",  32'(out_last),  32'(snap.last));
                checkOutput("hold_err",   32'(err),       32'(snap.err));
                checkOutput("hold_beats", 32'(beats),     32'(snap.beats));
            end
            if (out_valid && !out_ready) begin
                held = 1'b1;
                snap_valid = out_valid;
                snap.data  = out_data;
                snap.ovf   = out_ovf;
                snap.last  = out_last;
                snap.err   = err;
                snap.beats = beats;
            end else begin
                held = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_beat", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    checkOutput("out_data",  32'(out_data), 32'(e.data));
                    checkOutput("out_ovf",   32'(out_ovf),  32'(e.ovf));
                    checkOutput("out_last",  32'(out_last), 32'(e.last));
                    checkOutput("err",       32'(err),      32'(e.err));
                    checkOutput("beats",     32'(beats),    32'(e.beats));
                end
            end
        end
    end

    initial begin
        logic [OW*N-1:0] p;
        int  acc;
        bit  f;
        bit  l;
        int  wait_n;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
        in_psum  = 'x;
        idle(3);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_last",  32'(out_last),  32'd0);
        checkOutput("rst_out_data",  32'(out_data),  32'd0);
        checkOutput("rst_out_ovf",   32'(out_ovf),   32'd0);
        checkOutput("rst_err",       32'(err),       32'd0);
        checkOutput("rst_beats",     32'(beats),     32'd0);
        checkOutput("rst_in_ready",  32'(in_ready),  32'd1);
        rst_n = 1'b1;
        idle(2);

        $display("[TB] two-beat stream");
        applyStimulus(mk(3, 7, 7, 12), 1'b1, 1'b0);
        applyStimulus(mk(14, 20, 20, 25), 1'b0, 1'b0);

        $display("[TB] wrap-around and err restart");
        applyStimulus(mk(60, 2, 5, 5), 1'b1, 1'b0);
        applyStimulus(mk(1, 3, 6, 10), 1'b1, 1'b0);
        idle(3);

        $display("[TB] backpressure");
        ready_mode = 2;
        idle(2);
        applyStimulus(mk(4, 8, 9, 30), 1'b1, 1'b0);
        fork
            applyStimulus(mk(33, 35, 40, 41), 1'b0, 1'b0);
        join_none
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
            checkOutput("stall_carry", 32'(dut.carry_q), 32'(m_carry));
        end
        ready_mode = 0;
        wait fork;
        idle(3);

        $display("[TB] carry cleared by in_last");
        applyStimulus(mk(1, 2, 3, 4), 1'b1, 1'b1);
        applyStimulus(mk(5, 5, 5, 5), 1'b0, 1'b0);
        applyStimulus(mk(7, 9, 9, 9), 1'b1, 1'b1);
        idle(3);

        $display("[TB] reset while holding a beat");
        ready_mode = 2;
        idle(2);
        applyStimulus(mk(9, 9, 9, 9), 1'b1, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_err",       32'(err),       32'd0);
        checkOutput("midrst_beats",     32'(beats),     32'd0);
        sb.delete();
        m_carry = 0;
        m_err   = 1'b0;
        m_beats = 0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ready_mode = 0;
        idle(1);
        applyStimulus(mk(2, 2, 2, 2), 1'b0, 1'b0);
        idle(3);

        $display("[TB] randomized beats");
        ready_mode = 1;
        for (int i = 0; i < 200; i++) begin
            f = ($urandom_range(0, 3) == 0);
            l = ($urandom_range(0, 3) == 0);
            acc = f ? 0 : m_carry;
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 7) == 0) acc = $urandom_range(0, 63);
                else acc = (acc + $urandom_range(0, 15)) % 64;
                p[k*OW +: OW] = acc[OW-1:0];
            end
            applyStimulus(p, f, l);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end

        ready_mode = 0;
        wait_n = 0;
        while (sb.size() != 0 && wait_n < 100) begin
            @(posedge clk);
            wait_n++;
        end
        idle(2);
        checkOutput("drain_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
